fifo_buffer_param: RTL and testbench

- Parametrised synchronous FIFO, next generation of the UART TX/RX byte buffer.
- Generalised data width and power-of-two depth, uses all DEPTH entries, and exposes occupancy.
- Adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a first-word-fall-through (FWFT) read mode.
- Sits between the bus-side register interface and the serial TX/RX engines.

---
 rtl/fifo_buffer_param_if.sv | 31 +++
 rtl/fifo_buffer_param.sv | 112 +++++++++++
 tb/tb_fifo_buffer_param.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_buffer_param_if.sv
// Write/read handshake and status bundle between the bus-side register block
// and a fifo_buffer_param instance; master drives requests, slave is the FIFO.
interface fifo_buffer_param_if #(
  parameter int WIDTH = 32'sd8,
  parameter int DEPTH = 32'sd8
) ();
  localparam int AW = $clog2(DEPTH);

  logic             writeEn;
  logic             readEn;
  logic [WIDTH-1:0] dataIn;
  logic             clr_err;
  logic [WIDTH-1:0] dataOut;
  logic [AW:0]      count;
  logic             EMPTY;
  logic             FULL;
  logic             ALMOST_EMPTY;
  logic             ALMOST_FULL;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport master (
    output writeEn, readEn, dataIn, clr_err,
    input  dataOut, count, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  writeEn, readEn, dataIn, clr_err,
    output dataOut, count, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/fifo_buffer_param.sv
// Parametrised synchronous FIFO with wrap-bit pointers, occupancy count,
// almost-full/empty thresholds, sticky error flags and optional FWFT read.
module fifo_buffer_param #(
  parameter int WIDTH    = 32'sd8,
  parameter int DEPTH    = 32'sd8,
  parameter int AF_LEVEL = DEPTH - 32'sd2,
  parameter int AE_LEVEL = 32'sd2,
  parameter int FWFT     = 32'sd0
) (
  input  logic                clk,
  input  logic                reset,
  fifo_buffer_param_if.slave  bus
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [AW:0] ONE_L = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_L  = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_L  = AE_LEVEL[AW:0];

  if ((DEPTH < 32'sd2) || ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0) ||
      (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_params
    $error("fifo_buffer_param: illegal DEPTH/AE_LEVEL/AF_LEVEL combination");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty_s, full_s, wa_s, ra_s;
  logic [WIDTH-1:0] head_s;

  // Next-state decode: accept decisions use flags as sampled before the edge.
  always_comb begin
    empty_s = (wptr_q == rptr_q);
    full_s  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    wa_s    = bus.writeEn & ~full_s;
    ra_s    = bus.readEn & ~empty_s;
    head_s  = mem_q[rptr_q[AW-1:0]];

    if (wa_s) begin
      wptr_d = wptr_q + ONE_L;
    end else begin
      wptr_d = wptr_q;
    end

    if (ra_s) begin
      rptr_d = rptr_q + ONE_L;
      dout_d = head_s;
    end else begin
      rptr_d = rptr_q;
      dout_d = dout_q;
    end

    case ({wa_s, ra_s})
      2'b10:   count_d = count_q + ONE_L;
      2'b01:   count_d = count_q - ONE_L;
      default: count_d = count_q;
    endcase

    // A fresh error in the same cycle as clr_err keeps the flag set.
    ovf_d = (bus.writeEn & full_s) | (ovf_q & ~bus.clr_err);
    unf_d = (bus.readEn & empty_s) | (unf_q & ~bus.clr_err);
  end

  // Output decode from registered state; FWFT masks the head word while empty.
  always_comb begin
    if (FWFT != 32'sd0) begin
      if (empty_s) begin
        bus.dataOut = {WIDTH{1'b0}};
      end else begin
        bus.dataOut = head_s;
      end
    end else begin
      bus.dataOut = dout_q;
    end
    bus.count        = count_q;
    bus.EMPTY        = empty_s;
    bus.FULL         = full_s;
    bus.ALMOST_EMPTY = (count_q <= AE_L);
    bus.ALMOST_FULL  = (count_q >= AF_L);
    bus.OVERFLOW     = ovf_q;
    bus.UNDERFLOW    = unf_q;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= {(AW+1){1'b0}};
      rptr_q  <= {(AW+1){1'b0}};
      count_q <= {(AW+1){1'b0}};
      dout_q  <= {WIDTH{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wa_s) begin
      mem_q[wptr_q[AW-1:0]] <= bus.dataIn;
    end
  end
endmodule

// File: tb/tb_fifo_buffer_param.sv
// Randomised and directed bench for fifo_buffer_param: one registered-read and one
// FWFT instance share stimulus and are checked against a queue-based model.
module tb_fifo_buffer_param;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = DEPTH - 2;
  localparam int AE_LEVEL = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic             cur_we, cur_re, cur_clr;
  logic [WIDTH-1:0] cur_din;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] model_dout;
  logic             model_ovf, model_unf;

  fifo_buffer_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_reg ();
  fifo_buffer_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_fwft ();

  fifo_buffer_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL),
                      .AE_LEVEL(AE_LEVEL), .FWFT(0)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_reg)
  );

  fifo_buffer_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL),
                      .AE_LEVEL(AE_LEVEL), .FWFT(1)) u_dut_fwft (
    .clk(clk), .reset(reset), .bus(bus_fwft)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [WIDTH-1:0] din, input logic clr);
    cur_we = we; cur_re = re; cur_din = din; cur_clr = clr;
    bus_reg.writeEn  = we;  bus_reg.readEn  = re;  bus_reg.dataIn  = din;  bus_reg.clr_err  = clr;
    bus_fwft.writeEn = we;  bus_fwft.readEn = re;  bus_fwft.dataIn = din;  bus_fwft.clr_err = clr;
  endtask

  task automatic model_reset();
    model_q.delete();
    model_dout = '0;
    model_ovf  = 1'b0;
    model_unf  = 1'b0;
  endtask

  // Behavioural FIFO: a queue of words plus the last word handed out.
  task automatic model_step();
    bit full, empty;
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    if (cur_we && full)       model_ovf = 1'b1;
    else if (cur_clr)         model_ovf = 1'b0;
    if (cur_re && empty)      model_unf = 1'b1;
    else if (cur_clr)         model_unf = 1'b0;
    if (cur_re && !empty)     model_dout = model_q.pop_front();
    if (cur_we && !full)      model_q.push_back(cur_din);
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    check("count",        bus_reg.count,        n);
    check("empty",        bus_reg.EMPTY,        n == 0);
    check("full",         bus_reg.FULL,         n == DEPTH);
    check("almost_empty", bus_reg.ALMOST_EMPTY, n <= AE_LEVEL);
    check("almost_full",  bus_reg.ALMOST_FULL,  n >= AF_LEVEL);
    check("overflow",     bus_reg.OVERFLOW,     model_ovf);
    check("underflow",    bus_reg.UNDERFLOW,    model_unf);
    check("dataout",      bus_reg.dataOut,      model_dout);
    check("fwft_count",   bus_fwft.count,       n);
    check("fwft_empty",   bus_fwft.EMPTY,       n == 0);
    check("fwft_ovf",     bus_fwft.OVERFLOW,    model_ovf);
    check("fwft_unf",     bus_fwft.UNDERFLOW,   model_unf);
    if (n != 0) check("fwft_head", bus_fwft.dataOut, model_q[0]);
  endtask

  task automatic cycle(input logic we, input logic re, input logic [WIDTH-1:0] din, input logic clr);
    drive(we, re, din, clr);
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (model_q.size() != 0) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    model_reset();
    #12;
    check("rst_count", bus_reg.count, 0);
    check("rst_empty", bus_reg.EMPTY, 1);
    check("rst_full",  bus_reg.FULL, 0);
    check("rst_ae",    bus_reg.ALMOST_EMPTY, 1);
    check("rst_af",    bus_reg.ALMOST_FULL, 0);
    check("rst_ovf",   bus_reg.OVERFLOW, 0);
    check("rst_unf",   bus_reg.UNDERFLOW, 0);
    check("rst_dout",  bus_reg.dataOut, 0);
    @(negedge clk);
    reset = 1'b1;

    // Fill with 0x11..0x88, then overflow with 0x99.
    for (int i = 1; i <= 8; i++) begin
      d = 8'(i * 17);
      cycle(1'b1, 1'b0, d, 1'b0);
      check("af_from_6", bus_reg.ALMOST_FULL, i >= 6);
    end
    check("fill_full",  bus_reg.FULL, 1);
    check("fill_count", bus_reg.count, 8);
    cycle(1'b1, 1'b0, 8'h99, 1'b0);
    check("ovf_set",    bus_reg.OVERFLOW, 1);
    check("ovf_count",  bus_reg.count, 8);

    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      d = 8'(i * 17);
      check("read_order", bus_reg.dataOut, d);
    end
    check("drain_empty", bus_reg.EMPTY, 1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("unf_set",   bus_reg.UNDERFLOW, 1);
    check("unf_hold",  bus_reg.dataOut, 8'h88);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_ovf",   bus_reg.OVERFLOW, 0);
    check("clr_unf",   bus_reg.UNDERFLOW, 0);

    // Pointer wrap.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    check("wrap_full", bus_reg.FULL, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("wrap_data", bus_reg.dataOut, 8'(8'h40 + i));
    end
    check("wrap_empty", bus_reg.EMPTY, 1);

    // Simultaneous traffic at count 3, then at FULL and at EMPTY.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 8'(8'h70 + i), 1'b0);
      check("rw_count3", bus_reg.count, 3);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    check("full_rw_count", bus_reg.count, 7);
    check("full_rw_ovf",   bus_reg.OVERFLOW, 1);
    drain();
    cycle(1'b1, 1'b1, 8'h3C, 1'b1);
    check("empty_rw_count", bus_reg.count, 1);
    check("empty_rw_unf",   bus_reg.UNDERFLOW, 1);
    drain();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // FWFT visibility.
    cycle(1'b1, 1'b0, 8'hA5, 1'b0);
    check("fwft_a5",       bus_fwft.dataOut, 8'hA5);
    check("fwft_nonempty", bus_fwft.EMPTY, 0);
    cycle(1'b1, 1'b0, 8'h5A, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("fwft_5a",       bus_fwft.dataOut, 8'h5A);
    drain();

    // Randomised traffic with varying write/read bias.
    for (int phase = 0; phase < 4; phase++) begin
      for (int i = 0; i < 100; i++) begin
        cycle(($urandom_range(3, 0) < (phase + 1)) ? 1'b1 : 1'b0,
              ($urandom_range(3, 0) < (4 - phase)) ? 1'b1 : 1'b0,
              8'($urandom), ($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0);
      end
    end

    // Asynchronous reset mid-burst at count 5 with an error flag set.
    drain();
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    check("pre_rst_count", bus_reg.count, 5);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count",     bus_reg.count, 0);
    check("arst_empty",     bus_reg.EMPTY, 1);
    check("arst_unf",       bus_reg.UNDERFLOW, 0);
    check("arst_ovf",       bus_reg.OVERFLOW, 0);
    check("arst_fwft_cnt",  bus_fwft.count, 0);
    check("arst_fwft_unf",  bus_fwft.UNDERFLOW, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, (i > 1) ? 1'b1 : 1'b0, 8'(8'hD0 + i), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
